mem_bus_arbiter: RTL and testbench

//  Shares the single downstream memory bus between the core's instruction-fetch port and data port.

---
 rtl/mem_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter between the fetch and data ports onto one memory bus,
// with address decode, ROM-write/unmapped error responses and a slave timeout.
//
// state | meaning
// IDLE  | waiting for a request; arbitration and decode happen here
// BUSY  | slv_valid held; waiting for slv_ready or timeout expiry
// ERR   | one-cycle error response to the granted port
module mem_bus_arbiter #(
  parameter logic [31:0] ROM_BASE   = 32'h0,
  parameter logic [31:0] ROM_TOP    = 32'h80,
  parameter logic [31:0] PRINT_BASE = 32'h1000000,
  parameter logic [31:0] PRINT_TOP  = 32'h1000004,
  parameter logic [31:0] CLINT_BASE = 32'h2000000,
  parameter logic [31:0] CLINT_TOP  = 32'h200C000,
  parameter logic [31:0] BRAM_BASE  = 32'h80000000,
  parameter logic [31:0] BRAM_TOP   = 32'h90000000,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,
  output logic        imem_error,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        dmem_error,
  output logic        slv_valid,
  output logic [3:0]  slv_sel,
  output logic        slv_instr,
  output logic [31:0] slv_addr,
  output logic [31:0] slv_wdata,
  output logic [3:0]  slv_wstrb,
  input  logic [31:0] slv_rdata,
  input  logic        slv_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LOAD = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t        state;
  logic          last_grant_d;
  logic          gnt_instr;
  logic [CW-1:0] tmo_cnt;

  function automatic logic [3:0] decode(input logic [31:0] a);
    logic [3:0] s;
    s[0] = (a >= ROM_BASE)   && (a < ROM_TOP);
    s[1] = (a >= PRINT_BASE) && (a < PRINT_TOP);
    s[2] = (a >= CLINT_BASE) && (a < CLINT_TOP);
    s[3] = (a >= BRAM_BASE)  && (a < BRAM_TOP);
    return s;
  endfunction

  logic        grant_d;
  logic [3:0]  i_sel, d_sel, g_sel;
  logic [31:0] g_addr;
  logic        g_ok;
  logic        tmo_hit;

  always_comb begin
    i_sel   = decode(imem_addr);
    d_sel   = decode(dmem_addr);
    // On contention the port that did not win last contention goes first.
    grant_d = dmem_valid && (!imem_valid || !last_grant_d);
    g_sel   = grant_d ? d_sel : i_sel;
    g_addr  = grant_d ? dmem_addr : imem_addr;
    g_ok    = (|g_sel) && !(grant_d && d_sel[0] && (dmem_wstrb != 4'h0));
    tmo_hit = (TIMEOUT != 0) && (tmo_cnt == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      gnt_instr    <= 1'b0;
      tmo_cnt      <= '0;
      slv_valid    <= 1'b0;
      slv_sel      <= 4'h0;
      slv_instr    <= 1'b0;
      slv_addr     <= 32'h0;
      slv_wdata    <= 32'h0;
      slv_wstrb    <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (imem_valid || dmem_valid) begin
            gnt_instr <= !grant_d;
            if (imem_valid && dmem_valid) last_grant_d <= grant_d;
            if (g_ok) begin
              slv_valid <= 1'b1;
              slv_sel   <= g_sel;
              slv_instr <= !grant_d;
              slv_addr  <= g_addr;
              slv_wdata <= grant_d ? dmem_wdata : 32'h0;
              slv_wstrb <= grant_d ? dmem_wstrb : 4'h0;
              tmo_cnt   <= TMO_LOAD;
              state     <= BUSY;
            end else begin
              state <= ERR;
            end
          end
        end
        BUSY: begin
          if (slv_ready) begin
            slv_valid <= 1'b0;
            slv_sel   <= 4'h0;
            tmo_cnt   <= '0;
            state     <= IDLE;
          end else if (tmo_hit) begin
            slv_valid <= 1'b0;
            slv_sel   <= 4'h0;
            tmo_cnt   <= '0;
            state     <= ERR;
          end else begin
            tmo_cnt <= tmo_cnt - CW'(1);
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic busy_done, err_st;

  always_comb begin
    busy_done  = (state == BUSY) && slv_ready;
    err_st     = (state == ERR);
    imem_ready = gnt_instr && (busy_done || err_st);
    dmem_ready = !gnt_instr && (busy_done || err_st);
    imem_error = gnt_instr && err_st;
    dmem_error = !gnt_instr && err_st;
    imem_rdata = (gnt_instr && busy_done) ? slv_rdata : 32'h0;
    dmem_rdata = (!gnt_instr && busy_done) ? slv_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed plus randomized bench for mem_bus_arbiter, checked against a
// transaction-level model of arbitration, decode and response timing.
module tb_mem_bus_arbiter;
  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_error;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_error;
  logic        slv_valid;
  logic [3:0]  slv_sel;
  logic        slv_instr;
  logic [31:0] slv_addr;
  logic [31:0] slv_wdata;
  logic [3:0]  slv_wstrb;
  logic [31:0] slv_rdata;
  logic        slv_ready;

  mem_bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_error(imem_error),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .dmem_error(dmem_error),
    .slv_valid(slv_valid), .slv_sel(slv_sel), .slv_instr(slv_instr),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
    .slv_rdata(slv_rdata), .slv_ready(slv_ready)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit m_last_d;   // model: data port won the last contention
  bit first_wd;   // which port the model granted first in the last serve call

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_sel(input logic [31:0] a);
    if (a < 32'h80) return 4'b0001;
    if (a >= 32'h1000000 && a < 32'h1000004) return 4'b0010;
    if (a >= 32'h2000000 && a < 32'h200C000) return 4'b0100;
    if (a >= 32'h80000000 && a < 32'h90000000) return 4'b1000;
    return 4'b0000;
  endfunction

  task automatic set_i(input logic [31:0] a);
    imem_valid = 1'b1; imem_addr = a;
  endtask

  task automatic set_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    dmem_valid = 1'b1; dmem_addr = a; dmem_wdata = wd; dmem_wstrb = ws;
  endtask

  // Services every pending request; entered #1 after a rising edge with the DUT idle.
  // lat = BUSY cycle in which the slave answers (0 or >TMO: never).
  task automatic serve(input int lat, input bit fixed_rd, input logic [31:0] rd_val);
    bit wd, err, tmo, first;
    logic [31:0] a, exp_rd;
    logic [3:0]  s;
    first = 1'b1;
    while (imem_valid || dmem_valid) begin
      wd = dmem_valid && (!imem_valid || !m_last_d);
      if (imem_valid && dmem_valid) m_last_d = wd;
      if (first) first_wd = wd;
      first = 1'b0;
      a   = wd ? dmem_addr : imem_addr;
      s   = model_sel(a);
      err = (s == 4'b0) || (wd && s == 4'b0001 && dmem_wstrb != 4'h0);
      tmo = 1'b0;
      @(negedge clock);
      chk("idle_irdy", imem_ready, 0);
      chk("idle_drdy", dmem_ready, 0);
      chk("idle_svalid", slv_valid, 0);
      @(posedge clock); #1;
      if (!err) begin
        tmo = (lat == 0) || (lat > TMO);
        for (int k = 1; k <= TMO; k++) begin
          exp_rd    = fixed_rd ? rd_val : $urandom;
          slv_rdata = exp_rd;
          slv_ready = (k == lat);
          @(negedge clock);
          chk("busy_svalid", slv_valid, 1);
          chk("busy_sel", slv_sel, s);
          chk("busy_addr", slv_addr, a);
          chk("busy_instr", slv_instr, !wd);
          chk("busy_wdata", slv_wdata, wd ? dmem_wdata : 32'h0);
          chk("busy_wstrb", slv_wstrb, wd ? dmem_wstrb : 4'h0);
          chk("busy_win_rdy", wd ? dmem_ready : imem_ready, k == lat);
          chk("busy_lose_rdy", wd ? imem_ready : dmem_ready, 0);
          chk("busy_err", wd ? dmem_error : imem_error, 0);
          if (k == lat) chk("busy_rdata", wd ? dmem_rdata : imem_rdata, exp_rd);
          @(posedge clock); #1;
          slv_ready = 1'b0;
          if (k == lat) break;
        end
      end
      if (err || tmo) begin
        @(negedge clock);
        chk("err_win_rdy", wd ? dmem_ready : imem_ready, 1);
        chk("err_win_err", wd ? dmem_error : imem_error, 1);
        chk("err_rdata", wd ? dmem_rdata : imem_rdata, 0);
        chk("err_lose_rdy", wd ? imem_ready : dmem_ready, 0);
        chk("err_svalid", slv_valid, 0);
        @(posedge clock); #1;
      end
      if (wd) dmem_valid = 1'b0; else imem_valid = 1'b0;
    end
  endtask

  logic [31:0] addr_tab [12];

  initial begin
    addr_tab = '{32'h0, 32'h40, 32'h7F, 32'h80, 32'h1000000, 32'h1000004,
                 32'h2000000, 32'h200BFFC, 32'h200C000, 32'h80000000,
                 32'h8FFFFFFC, 32'h90000000};
    reset = 1'b1;
    imem_valid = 0; imem_addr = 0;
    dmem_valid = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0;
    slv_rdata = 0; slv_ready = 0;
    m_last_d = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_irdy", imem_ready, 0);
    chk("rst_drdy", dmem_ready, 0);
    chk("rst_svalid", slv_valid, 0);
    chk("rst_sel", slv_sel, 0);
    chk("rst_addr", slv_addr, 0);
    chk("rst_derr", dmem_error, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // bram read
    set_d(32'h80000010, 32'h0, 4'h0);
    serve(1, 1'b1, 32'hDEADBEEF);

    // three contentions: D, I, D
    for (int r = 0; r < 3; r++) begin
      set_i(32'h10); set_d(32'h80000020, 32'h0, 4'h0);
      serve(1, 1'b0, 32'h0);
      chk("rr_order", first_wd, (r == 1) ? 0 : 1);
    end

    // errors and ROM edge
    set_d(32'h40, 32'h12345678, 4'hF); serve(1, 1'b0, 0);
    set_d(32'h3000000, 32'h0, 4'h0);   serve(1, 1'b0, 0);
    set_d(32'h7F, 32'h0, 4'h0);        serve(1, 1'b0, 0);
    set_i(32'h40);                     serve(2, 1'b0, 0);

    // window boundaries
    set_d(32'h1000003, 32'hA5A5A5A5, 4'h1); serve(1, 1'b0, 0);
    set_d(32'h1000004, 32'h0, 4'h0);        serve(1, 1'b0, 0);
    set_d(32'h8FFFFFFC, 32'h0, 4'h0);       serve(1, 1'b0, 0);
    set_d(32'h90000000, 32'h0, 4'h0);       serve(1, 1'b0, 0);
    set_i(32'h200C000);                     serve(1, 1'b0, 0);
    set_i(32'h200BFFC);                     serve(3, 1'b0, 0);

    // timeout, then answer in the last allowed cycle
    set_d(32'h80000100, 32'h0, 4'h0); serve(0, 1'b0, 0);
    set_d(32'h80000100, 32'h0, 4'h0); serve(TMO, 1'b0, 0);
    set_i(32'h20);                    serve(0, 1'b0, 0);

    // reset during BUSY
    set_d(32'h80000200, 32'h0, 4'h0);
    @(posedge clock); #1;
    chk("pre_rst_svalid", slv_valid, 1);
    slv_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rst_drdy", dmem_ready, 0);
    chk("mid_rst_irdy", imem_ready, 0);
    chk("mid_rst_svalid", slv_valid, 0);
    chk("mid_rst_sel", slv_sel, 0);
    chk("mid_rst_addr", slv_addr, 0);
    chk("mid_rst_drdata", dmem_rdata, 0);
    dmem_valid = 1'b0; slv_ready = 1'b0;
    @(posedge clock); #1;
    chk("in_rst_drdy", dmem_ready, 0);
    reset = 1'b0;
    m_last_d = 1'b0;
    @(posedge clock); #1;
    set_d(32'h80000204, 32'h0, 4'h0); serve(1, 1'b0, 0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      int li;
      bit vi, vd;
      vi = 1'($urandom_range(0, 1));
      vd = 1'($urandom_range(0, 1));
      if (!vi && !vd) vd = 1'b1;
      if (vi) set_i(addr_tab[$urandom_range(0, 11)]);
      if (vd) set_d(addr_tab[$urandom_range(0, 11)] + 32'($urandom_range(0, 1) * 4),
                    $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0);
      li = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 3));
      serve(li, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
